muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative 32-bit multiply/divide unit for MULT/MULTU/DIV/DIVU. Sits downstream
//  of the register file read ports (operands = rs/rt read values) and holds the
//  HI/LO result registers read by MFHI/MFLO. Stalls the core while an operation
//  runs; one shift-add or restore-subtract step per clock.
// PARAMETERS
//  WIDTH   32   operand width; HI/LO are WIDTH bits each, iteration count = WIDTH
// PORTS
//  clk      in   1      core clock; all state changes on posedge clk
//  rst_n    in   1      synchronous, active-low reset
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  rs_val   in   WIDTH  multiplicand / dividend (register file read port 1)
//  rt_val   in   WIDTH  multiplier / divisor (register file read port 2)
//  busy     out  1      op in flight; core must stall issue of mul/div/MFHI/MFLO
//  done     out  1      one-cycle pulse: new HI/LO visible this cycle
//  hi       out  WIDTH  product[2W-1:W] or remainder
//  lo       out  WIDTH  product[W-1:0] or quotient
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//  Reset mid-operation aborts it; hi/lo are cleared, no done pulse follows.
//  FSM: IDLE -start-> RUN -(counter==WIDTH-1)-> FIX -> DONE -> IDLE.
//   IDLE: latch op, sign flags, |rs_val|,|rt_val| (abs only when op[0]=1); counter=0.
//   RUN : WIDTH cycles. Mul: if acc_lo[0] add multiplicand into acc_hi (W+1-bit
//         sum), shift {carry,acc_hi,acc_lo} right 1. Div: shift {rem,quo} left 1,
//         trial rem-divisor; if non-negative keep and set quo[0].
//   FIX : signed mul: negate 2W product if signs differ. signed div: negate
//         quotient if signs differ; remainder takes dividend's sign.
//   DONE: hi/lo loaded from result; done=1 for exactly this cycle; busy=0.
//  Latency: start sampled at edge 0 -> busy=1 from edge 1 through edge WIDTH+1;
//  done=1 and new hi/lo visible after edge WIDTH+2. Throughput one op / WIDTH+3.
//  hi/lo hold previous result unchanged until the DONE cycle.
//  start while busy or in DONE: ignored, no queueing; operands not re-sampled.
//  start in IDLE on the cycle after DONE is accepted (back-to-back allowed).
//  Divide by zero: no trap; hi=rs_val (dividend, unmodified), lo={WIDTH{1'b1}}.
//  DIV -2^(W-1) / -1: lo=0x80000000, hi=0 (falls out of magnitude path, no flag).
//  Magnitude of -2^(W-1) is 2^(W-1) treated unsigned; no overflow detection.
//  All arithmetic modulo 2^WIDTH per half; no X propagation from unused op bits.
// STRUCTURE
//  muldiv_defs.vh (shared include): op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV,
//  FSM state codes S_IDLE/S_RUN/S_FIX/S_DONE; reused by decoder and hazard unit.
//  Sub-module muldiv_signfix: combinational abs-in / conditional-negate-out
//  helper instantiated for operand conditioning and the FIX step.
//  Single datapath: acc_hi, acc_lo, operand_b (WIDTH each), 6-bit counter.
// TESTING
//  1 MULTU 0xFFFFFFFF*0xFFFFFFFF -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001.
//  2 MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000*0x80000000 ->
//    hi=0x40000000, lo=0.
//  3 DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2;
//    DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4 DIVU 0x1234/0 -> hi=0x00001234, lo=0xFFFFFFFF, done pulse still 1 cycle.
//  5 start pulsed every cycle during RUN with changed operands -> result matches
//    first op only; busy stays high; back-to-back start at DONE+1 accepted.
//  6 rst_n=0 at RUN counter=10 -> next cycle busy=0, done=0, hi=lo=0; no later done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state codes and small op-decode helpers.
package muldiv_unit_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Divide ops live in the upper half of the encoding.
  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIVU) || (op == OP_DIV);
  endfunction

  // Signed variants have the low encoding bit set.
  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_signfix.sv
// Conditional two's-complement negate; used both as |x| on the way in and
// as the sign restore on the way out.
module muldiv_unit_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  // Negate when requested, pass through otherwise.
  always_comb begin
    res = val;
    if (neg) begin
      res = (~val) + W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide unit holding the HI/LO result pair.
// One shift-add (mul) or restoring-subtract (div) step per clock on
// operand magnitudes, followed by a sign-fix cycle and a result-publish cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  state_e             state;
  logic [CNT_W-1:0]   counter;
  logic               is_div;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand_b;

  logic               in_neg_a;
  logic               in_neg_b;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               trial_ok;
  logic [WIDTH-1:0]   div_diff;

  assign in_neg_a = op_is_signed(op) & rs_val[WIDTH-1];
  assign in_neg_b = op_is_signed(op) & rt_val[WIDTH-1];

  muldiv_unit_signfix #(.W(WIDTH)) u_abs_a (
    .val (rs_val),
    .neg (in_neg_a),
    .res (abs_a)
  );

  muldiv_unit_signfix #(.W(WIDTH)) u_abs_b (
    .val (rt_val),
    .neg (in_neg_b),
    .res (abs_b)
  );

  muldiv_unit_signfix #(.W(2*WIDTH)) u_fix_prod (
    .val ({acc_hi, acc_lo}),
    .neg (neg_a ^ neg_b),
    .res (prod_fix)
  );

  muldiv_unit_signfix #(.W(WIDTH)) u_fix_quo (
    .val (acc_lo),
    .neg (neg_a ^ neg_b),
    .res (quo_fix)
  );

  muldiv_unit_signfix #(.W(WIDTH)) u_fix_rem (
    .val (acc_hi),
    .neg (neg_a),
    .res (rem_fix)
  );

  // One iteration step: add-shift for mul, shift and trial-subtract for div.
  // A carry out of the shifted remainder means it already exceeds any divisor.
  always_comb begin
    mul_sum   = {1'b0, acc_hi};
    if (acc_lo[0]) begin
      mul_sum = {1'b0, acc_hi} + {1'b0, operand_b};
    end
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    trial_ok  = div_shift[WIDTH] | (div_shift[WIDTH-1:0] >= operand_b);
    div_diff  = div_shift[WIDTH-1:0] - operand_b;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      counter   <= '0;
      is_div    <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op_is_div(op);
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            counter <= '0;
            acc_hi  <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
            if (op_is_div(op)) begin
              acc_lo    <= abs_a;
              operand_b <= abs_b;
            end else begin
              acc_lo    <= abs_b;
              operand_b <= abs_a;
            end
          end
        end
        S_RUN: begin
          if (is_div) begin
            acc_hi <= trial_ok ? div_diff : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], trial_ok};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          counter <= counter + CNT_W'(1);
          if (counter == CNT_W'(WIDTH - 1)) begin
            state <= S_FIX;
          end
        end
        S_FIX: begin
          if (is_div) begin
            // Divide by zero leaves the dividend as remainder and all-ones quotient.
            acc_hi <= rem_fix;
            acc_lo <= (operand_b == '0) ? '1 : quo_fix;
          end else begin
            {acc_hi, acc_lo} <= prod_fix;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          hi    <= acc_hi;
          lo    <= acc_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level behavioural model compared
// every cycle, plus directed cases with hand-computed results.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  rs_val = '0;
  logic [W-1:0]  rt_val = '0;
  logic          busy;
  logic          done;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one op, straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = {32'b0, a} * {32'b0, b};
      2'b01: p = 64'(sa * sb);
      2'b10: p = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: begin
        if (b == 0) begin
          p = {a, 32'hFFFF_FFFF};
        end else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Cycle model: accept when idle, publish the result LAT edges later.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] m_pend = '0;
  int          m_cd = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_cd   <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_cd != 0) begin
        m_cd <= m_cd - 1;
        if (m_cd == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
        end
      end else if (start) begin
        m_pend <= ref_result(op, rs_val, rt_val);
        m_cd   <= LAT;
        m_busy <= 1'b1;
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 64'(busy), 64'(m_busy));
      chk("cyc_done", 64'(done), 64'(m_done));
      chk("cyc_hi", 64'(hi), 64'(m_hi));
      chk("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  // Directed op with literal expected result and latency.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string nm);
    int  lat;
    bit  seen;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    lat = 0;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    chk({nm, "_seen"}, 64'(seen), 64'(1));
    chk({nm, "_lat"}, 64'(lat), 64'(LAT));
    chk({nm, "_hi"}, 64'(hi), 64'(eh));
    chk({nm, "_lo"}, 64'(lo), 64'(el));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h1;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Random op with random start noise while busy; model checks the result.
  task automatic run_rand();
    bit seen;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    op = 2'($urandom_range(0, 3)); rs_val = pick_operand(); rt_val = pick_operand();
    start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1));
      op = 2'($urandom_range(0, 3)); rs_val = $urandom; rt_val = $urandom;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("rand_done_seen", 64'(seen), 64'(1));
    // A noise start on the done cycle may launch another op; let it drain.
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
  endtask

  initial begin
    bit seen;
    bit late_done;

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk_en = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg3x7");
    run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, "mult_min_sq");
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2");
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_min_m1");
    run_op(2'b10, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");
    @(negedge clk);
    chk("divu_by0_pulse", 64'(done), 64'(0));
    run_op(2'b11, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF, "div_by0_neg");

    // Start held during RUN with changed operands must be ignored.
    @(negedge clk);
    op = 2'b00; rs_val = 32'd5; rt_val = 32'd6; start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      chk("noise_busy", 64'(busy), 64'(1));
      start = 1'b1; op = 2'($urandom_range(0, 3)); rs_val = $urandom; rt_val = $urandom;
    end
    chk("noise_seen", 64'(seen), 64'(1));
    chk("noise_hi", 64'(hi), 64'(0));
    chk("noise_lo", 64'(lo), 64'(30));
    // Back-to-back: start on the done cycle is accepted at the next edge.
    op = 2'b10; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 64'(busy), 64'(1));
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("b2b_seen", 64'(seen), 64'(1));
    chk("b2b_hi", 64'(hi), 64'(2));
    chk("b2b_lo", 64'(lo), 64'(14));

    // Random ops
    for (int n = 0; n < 40; n++) begin
      run_rand();
    end

    // Reset while the counter reads 10 aborts the op and clears HI/LO.
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, "pre_abort");
    @(negedge clk);
    op = 2'b00; rs_val = $urandom; rt_val = $urandom; start = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hi", 64'(hi), 64'(0));
    chk("abort_lo", 64'(lo), 64'(0));
    late_done = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (done) late_done = 1'b1;
    end
    chk("abort_no_done", 64'(late_done), 64'(0));

    run_op(2'b01, 32'd12, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFE8, "post_abort");

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
